fft8_frame_loader: RTL and testbench
====================================

Name: fft8_frame_loader

Overview:
Upstream stage of the 8-point FFT datapath. Accepts a serial stream of 8-bit real samples over a valid/ready handshake and assembles 8-sample frames in a ping-pong (two-bank) buffer. Presents each complete frame in parallel on A0..A7 in natural order, for the combinational FFT core. Each frame is held stable until the consumer accepts it, while the other bank keeps filling.

Parameters:
DATA_W, 8, sample width in bits; applies to in_data and A0..A7.
PAD_VALUE, 0, value written into unfilled slots on flush.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data carries a sample
in_ready  output  1  loader can accept a sample this cycle
in_data  input  DATA_W  sample, time order n = 0..7 within a frame
flush  input  1  close the partially filled frame, padding it with PAD_VALUE
out_valid  output  1  A0..A7 hold a complete frame
out_ready  input  1  consumer takes the frame this cycle
A0..A7  output  DATA_W each  frame samples x[0]..x[7], registered, stable while out_valid=1
out_padded  output  1  presented frame was closed by flush (qualified by out_valid)
frame_cnt  output  16  count of frames handed off (out_valid&out_ready), wraps 0xFFFF->0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - Both banks EMPTY, wr_bank=0, wr_idx=0, rd_bank=0.
  - out_valid=0, out_padded=0, frame_cnt=0, A0..A7=0.
  - in_ready=1 from the first cycle after reset is released.
- Reset mid-operation discards all buffered samples, including a partial frame and a frame being presented.
- Bank states: EMPTY -> FILLING -> FULL -> EMPTY.
  - EMPTY -> FILLING: first accepted sample.
  - FILLING -> FULL: 8th sample, or a qualifying flush.
  - FULL -> EMPTY: handoff (out_valid & out_ready).
  - Only the write bank fills; only the read bank presents.
- Accept rule: a sample is accepted when in_valid & in_ready.
  - It is stored at slot wr_idx of the write bank, then wr_idx increments.
  - in_ready = 1 when the write bank is not FULL.
- Frame complete on slot 7 (or on flush):
  - Write bank -> FULL, wr_idx -> 0.
  - If the other bank is EMPTY, wr_bank toggles next cycle.
  - Otherwise in_ready drops until the other bank empties.
- Output latency: the sample completing a frame is accepted at edge t. Then, if no frame is being presented, out_valid=1 and A0..A7 are valid after edge t+1 (one-cycle registered). A0 = first accepted sample.
- Holding a frame: while out_valid=1 & out_ready=0, A0..A7 and out_padded hold their values.
- Handoff (out_valid & out_ready): read bank -> EMPTY, frame_cnt++.
  - If the other bank is FULL, its frame is presented on the next cycle: out_valid stays 1, no bubble.
  - Otherwise out_valid -> 0.
- Sustained rate: with out_ready tied 1, one sample per cycle is accepted indefinitely and in_ready never drops.
- Simultaneous handoff and frame completion in the same cycle: both take effect. The newly full bank presents next cycle and in_ready stays 1.
- Both banks FULL: in_ready=0, and input is stalled until the next handoff. in_ready rises the cycle after that handoff.
- Flush:
  - Sampled only when wr_idx>0 or a sample is accepted the same cycle.
  - Slots from the next free index through 7 are written with PAD_VALUE, and the bank goes FULL with its padded flag set.
  - flush with in_valid & in_ready in the same cycle: the sample is stored first, then the rest is padded.
  - flush with wr_idx=0 and no sample accepted: no effect.
  - flush while the write bank is FULL: ignored.
- Counter: frame_cnt is 16-bit unsigned and wraps silently.
- Data: samples are stored unmodified (no sign handling, no scaling); the width is DATA_W.

Decomposition:
- Shared package fft_pkg:
  - Localparam FFT_N=8 and its log2 index width (3).
  - The bank-state enum (EMPTY/FILLING/FULL).
  - The sample typedef of DATA_W bits.
- Natural sub-module: fft8_frame_bank. It holds one 8-entry register bank with write-enable/index, pad-fill, a padded flag and a state register. It is instantiated twice, and the top holds the ping-pong control and counter.

Test Plan:
- Reset, then stream 1..8 on consecutive cycles with out_ready=0 -> out_valid rises one cycle after the 8th acceptance, A0..A7=1..8, out_padded=0, and the values stay stable while out_ready=0.
- Streams 1..8 then 9..16 with out_ready=0 throughout -> in_ready drops after the 16th sample. Pulse out_ready -> next cycle A0..A7=9..16 with no bubble, in_ready=1, frame_cnt=1.
- Samples 0x10,0x20,0x30 then flush -> frame A0..A7=0x10,0x20,0x30,0,0,0,0,0 and out_padded=1. A flush pulse at wr_idx=0 produces no frame.
- in_valid and out_ready tied 1, stream 0..63 -> in_ready never drops, 8 frames come out in order, frame_cnt=8.
- Assert rst while a frame is presented and 3 samples are pending -> next cycle out_valid=0, frame_cnt=0, in_ready=1. The following 8 samples form a fresh frame starting at A0.
- Preset frame_cnt near wrap (0xFFFF handoffs, or a forced value) -> the next handoff gives frame_cnt=0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT datapath.
package fft_pkg;

    localparam int FFT_N    = 8;
    localparam int IDX_W    = 3;
    localparam int SAMPLE_W = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

endpackage

// File: rtl/fft8_frame_bank.sv
// One 8-entry sample bank of the ping-pong frame buffer: slot writes,
// pad-fill on flush, a padded flag and the EMPTY/FILLING/FULL state.
module fft8_frame_bank
    import fft_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          pad_en,
    input  logic                          complete,
    input  logic                          release_bank,
    output bank_state_t                   state,
    output logic [FFT_N-1:0][DATA_W-1:0]  data,
    output logic                          padded
);

    bank_state_t state_nxt;

    // Slot storage: the written slot wins; on flush every slot from wr_idx up is padded.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FFT_N; i++) begin
            if (wr_en && (wr_idx == IDX_W'(i))) begin
                data[i] <= wr_data;
            end else if (pad_en && (IDX_W'(i) >= wr_idx)) begin
                data[i] <= PAD_VALUE;
            end
        end
    end

    // State register and padded flag, latched when the frame closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            padded <= 1'b0;
        end else begin
            state <= state_nxt;
            if (complete) begin
                padded <= pad_en;
            end
        end
    end

    // Bank lifecycle: fill on first sample, close on last sample or flush, empty on handoff.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (complete)    state_nxt = FULL;
                else if (wr_en)  state_nxt = FILLING;
            end
            FILLING: begin
                if (complete)    state_nxt = FULL;
            end
            FULL: begin
                if (release_bank) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

endmodule

// File: rtl/fft8_frame_loader.sv
// Serial-to-parallel frame loader: fills two banks alternately and presents
// each complete frame on A0..A7 until the consumer takes it.
module fft8_frame_loader
    import fft_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] A0,
    output logic [DATA_W-1:0] A1,
    output logic [DATA_W-1:0] A2,
    output logic [DATA_W-1:0] A3,
    output logic [DATA_W-1:0] A4,
    output logic [DATA_W-1:0] A5,
    output logic [DATA_W-1:0] A6,
    output logic [DATA_W-1:0] A7,
    output logic              out_padded,
    output logic [15:0]       frame_cnt
);

    bank_state_t                  bank_st   [2];
    logic [FFT_N-1:0][DATA_W-1:0] bank_data [2];
    logic                         bank_pad  [2];

    logic                         wr_bank;
    logic                         rd_bank;
    logic [IDX_W-1:0]             wr_idx;
    logic [FFT_N-1:0][DATA_W-1:0] frame_p1;

    logic accept;
    logic flush_q;
    logic complete;
    logic handoff;
    logic other_empty_nxt;
    logic wr_full_nxt;
    logic toggle_wr;

    assign in_ready = (bank_st[wr_bank] != FULL);
    assign accept   = in_valid & in_ready;
    assign flush_q  = flush & in_ready & ((wr_idx != '0) | accept);
    assign complete = (accept & (wr_idx == IDX_W'(FFT_N - 1))) | flush_q;
    assign handoff  = out_valid & out_ready;

    // The other bank is free after this edge if it is empty or its frame is being taken now.
    assign other_empty_nxt = (bank_st[~wr_bank] == EMPTY) | (handoff & (rd_bank != wr_bank));
    assign wr_full_nxt     = (bank_st[wr_bank] == FULL) | complete;
    assign toggle_wr       = wr_full_nxt & other_empty_nxt;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft8_frame_bank #(
            .DATA_W    (DATA_W),
            .PAD_VALUE (PAD_VALUE)
        ) u_bank (
            .clk          (clk),
            .rst          (rst),
            .wr_en        (accept   & (wr_bank == 1'(b))),
            .wr_idx       (wr_idx),
            .wr_data      (in_data),
            .pad_en       (flush_q  & (wr_bank == 1'(b))),
            .complete     (complete & (wr_bank == 1'(b))),
            .release_bank (handoff  & (rd_bank == 1'(b))),
            .state        (bank_st[b]),
            .data         (bank_data[b]),
            .padded       (bank_pad[b])
        );
    end

    // Write side: slot index and ping-pong bank select.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx  <= '0;
            wr_bank <= 1'b0;
        end else begin
            if (complete)    wr_idx <= '0;
            else if (accept) wr_idx <= wr_idx + 1'b1;
            if (toggle_wr)   wr_bank <= ~wr_bank;
        end
    end

    // ---- stage p1: registered frame presentation and handoff accounting ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_padded <= 1'b0;
            rd_bank    <= 1'b0;
            frame_cnt  <= '0;
            frame_p1   <= '0;
        end else if (handoff) begin
            frame_cnt <= frame_cnt + 16'd1;
            rd_bank   <= ~rd_bank;
            if (bank_st[~rd_bank] == FULL) begin
                frame_p1   <= bank_data[~rd_bank];
                out_padded <= bank_pad[~rd_bank];
                out_valid  <= 1'b1;
            end else begin
                out_valid  <= 1'b0;
            end
        end else if (!out_valid && (bank_st[rd_bank] == FULL)) begin
            frame_p1   <= bank_data[rd_bank];
            out_padded <= bank_pad[rd_bank];
            out_valid  <= 1'b1;
        end
    end

    assign A0 = frame_p1[0];
    assign A1 = frame_p1[1];
    assign A2 = frame_p1[2];
    assign A3 = frame_p1[3];
    assign A4 = frame_p1[4];
    assign A5 = frame_p1[5];
    assign A6 = frame_p1[6];
    assign A7 = frame_p1[7];

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Scoreboard bench for fft8_frame_loader: stimulus queues expected frames,
// a monitor compares each frame taken by the consumer.
module tb_fft8_frame_loader;

    typedef struct {
        logic [7:0][7:0] d;
        logic            padded;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  A0, A1, A2, A3, A4, A5, A6, A7;
    logic        out_padded;
    logic [15:0] frame_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic stall_seen = 1'b0;
    exp_t exp_q[$];

    fft8_frame_loader #(.DATA_W(8), .PAD_VALUE(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .A0         (A0),
        .A1         (A1),
        .A2         (A2),
        .A3         (A3),
        .A4         (A4),
        .A5         (A5),
        .A6         (A6),
        .A7         (A7),
        .out_padded (out_padded),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] got_frame();
        return {A7, A6, A5, A4, A3, A2, A1, A0};
    endfunction

    // Monitor: every frame the consumer takes must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL frame_unexpected: got %h padded=%0b, required no frame", got_frame(), out_padded);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (got_frame() !== e.d || out_padded !== e.padded) begin
                    n_fail++;
                    $display("FAIL frame_data: got %h padded=%0b, required %h padded=%0b",
                             got_frame(), out_padded, e.d, e.padded);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic f);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        flush    = f;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            if (!ok) stall_seen = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: sample %h not accepted, required acceptance", d);
        end
    endtask

    task automatic pulse_ready();
        out_ready = 1'b1;
        @(negedge clk);
        chk("handoff_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_seq(input logic [7:0] base);
        exp_t e;
        for (int i = 0; i < 8; i++) e.d[i] = base + 8'(i);
        e.padded = 1'b0;
        exp_q.push_back(e);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] snap;
        exp_t        e;

        // Reset state
        cycles(2);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_A",         got_frame(),    64'd0);
        rst = 1'b0;
        cycles(1);

        // Frame 1..8, held while out_ready=0
        push_seq(8'd1);
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        chk("lat_valid_low", 64'(out_valid), 64'd0);
        cycles(1);
        chk("lat_valid_high", 64'(out_valid), 64'd1);
        chk("frame1_A", got_frame(), 64'h0807060504030201);
        chk("frame1_pad", 64'(out_padded), 64'd0);
        snap = got_frame();
        cycles(3);
        chk("frame1_hold", got_frame(), snap);

        // Second frame fills the other bank, then input stalls
        push_seq(8'd9);
        for (int i = 9; i <= 16; i++) send(8'(i), 1'b0);
        chk("both_full_in_ready", 64'(in_ready), 64'd0);
        pulse_ready();
        chk("nobubble_valid", 64'(out_valid), 64'd1);
        chk("nobubble_A", got_frame(), 64'h100F0E0D0C0B0A09);
        chk("after_handoff_in_ready", 64'(in_ready), 64'd1);
        chk("cnt_1", 64'(frame_cnt), 64'd1);
        pulse_ready();
        chk("drained_valid", 64'(out_valid), 64'd0);
        chk("cnt_2", 64'(frame_cnt), 64'd2);

        // Flush after three samples
        e.d = 64'h0000000000302010;
        e.padded = 1'b1;
        exp_q.push_back(e);
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        cycles(1);
        chk("flush_valid", 64'(out_valid), 64'd1);
        chk("flush_pad", 64'(out_padded), 64'd1);
        chk("flush_A", got_frame(), 64'h0000000000302010);
        pulse_ready();

        // Flush with an empty write bank has no effect
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        cycles(3);
        chk("idle_flush_valid", 64'(out_valid), 64'd0);
        chk("idle_flush_in_ready", 64'(in_ready), 64'd1);

        // Flush together with a sample: sample stored, remainder padded
        e.d = 64'h0000000000006655;
        e.padded = 1'b1;
        exp_q.push_back(e);
        send(8'h55, 1'b0);
        send(8'h66, 1'b1);
        cycles(1);
        chk("flush_same_cycle_A", got_frame(), 64'h0000000000006655);
        pulse_ready();
        chk("cnt_4", 64'(frame_cnt), 64'd4);

        // Sustained stream 0..63 with out_ready tied high
        out_ready  = 1'b1;
        stall_seen = 1'b0;
        for (int f = 0; f < 8; f++) push_seq(8'(f * 8));
        for (int i = 0; i < 64; i++) send(8'(i), 1'b0);
        cycles(4);
        chk("stream_no_stall", 64'(stall_seen), 64'd0);
        chk("stream_cnt", 64'(frame_cnt), 64'd12);
        chk("stream_drained", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Reset while a frame is presented and 3 samples pending
        for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), 1'b0);
        for (int i = 0; i < 3; i++) send(8'hB0 + 8'(i), 1'b0);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        exp_q.delete();
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_cnt", 64'(frame_cnt), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        push_seq(8'hC0);
        for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i), 1'b0);
        cycles(1);
        chk("fresh_frame_A", got_frame(), 64'hC7C6C5C4C3C2C1C0);

        // Counter wrap
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        pulse_ready();
        chk("cnt_wrap", 64'(frame_cnt), 64'd0);

        cycles(2);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
